bb_phase_detector: RTL and testbench

- Bang-bang phase detector with majority-vote decimation.
- Compares rising edges of the reference clock and the DCO feedback clock, both oversampled by the system clock.
- Emits one early/late decision bit `x` per vote window, plus a strobe.
- `x` drives the integral/proportional adder stage of the PLL loop filter; this block is the producer side of that `x` interface.

---
 rtl/bb_phase_detector.sv | 199 +++++++++++++++++++
 tb/tb_bb_phase_detector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bb_phase_detector.sv
// ============================================================================
//  Module   : bb_phase_detector
//  Brief    : Bang-bang phase detector with majority-vote decimation. Optional
//             lock detector enabled by defining BBPD_LOCK_DET_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bb_phase_detector #(
    parameter int VOTE_LEN = 8,
    parameter int TIMEOUT  = 64,
    parameter int LOCK_CNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_in,
    input  logic fb_in,
    output logic x,
    output logic x_valid,
    output logic timeout,
    output logic lock
);

    localparam int c_sum_w = $clog2(VOTE_LEN) + 2;
    localparam int c_cnt_w = (VOTE_LEN > 1) ? $clog2(VOTE_LEN) : 1;
    localparam int c_tmr_w = $clog2(TIMEOUT);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_wait_fb  = 2'd1;
    localparam logic [1:0] c_st_wait_ref = 2'd2;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(VOTE_LEN - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);
    localparam logic signed [c_sum_w-1:0] c_plus_one  = {{(c_sum_w-1){1'b0}}, 1'b1};
    localparam logic signed [c_sum_w-1:0] c_minus_one = {c_sum_w{1'b1}};

    if ((VOTE_LEN < 1) || (TIMEOUT < 2) || (LOCK_CNT < 1)) begin : g_param_check
        $error("bb_phase_detector: illegal parameter value");
    end

    logic                      r_ref_q;
    logic                      r_fb_q;
    logic [1:0]                r_state;
    logic [c_tmr_w-1:0]        r_timer;
    logic [c_cnt_w-1:0]        r_cnt;
    logic signed [c_sum_w-1:0] r_sum;
    logic                      r_x;
    logic                      r_x_valid;
    logic                      r_timeout;

    logic                      w_ref_rise;
    logic                      w_fb_rise;
    logic [1:0]                w_state_nxt;
    logic [c_tmr_w-1:0]        w_timer_nxt;
    logic                      w_vote;
    logic                      w_vote_up;
    logic                      w_timeout;
    logic signed [c_sum_w-1:0] w_vote_val;
    logic signed [c_sum_w-1:0] w_sum_nxt;
    logic                      w_last;
    logic                      w_x_nxt;

    assign w_ref_rise = ref_in & ~r_ref_q;
    assign w_fb_rise  = fb_in  & ~r_fb_q;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + 1'b1;
        w_vote      = 1'b0;
        w_vote_up   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_timer_nxt = '0;
                if (w_ref_rise && !w_fb_rise) begin
                    w_state_nxt = c_st_wait_fb;
                end else if (w_fb_rise && !w_ref_rise) begin
                    w_state_nxt = c_st_wait_ref;
                end
            end
            c_st_wait_fb: begin
                if (w_fb_rise) begin
                    w_vote      = 1'b1;
                    w_vote_up   = 1'b1;
                    w_timer_nxt = '0;
                    // A coincident ref edge opens the next comparison at once
                    w_state_nxt = w_ref_rise ? c_st_wait_fb : c_st_idle;
                end else if (w_ref_rise) begin
                    w_timer_nxt = '0;
                end else if (r_timer == c_tmr_last) begin
                    w_timeout   = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_wait_ref: begin
                if (w_ref_rise) begin
                    w_vote      = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = w_fb_rise ? c_st_wait_ref : c_st_idle;
                end else if (w_fb_rise) begin
                    w_timer_nxt = '0;
                end else if (r_timer == c_tmr_last) begin
                    w_timeout   = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign w_vote_val = w_vote_up ? c_plus_one : c_minus_one;
    assign w_sum_nxt  = r_sum + w_vote_val;
    assign w_last     = w_vote && (r_cnt == c_cnt_last);

    // A tied window leaves the previous decision in place
    always_comb begin
        w_x_nxt = r_x;
        if (w_last && (w_sum_nxt != '0)) begin
            w_x_nxt = ~w_sum_nxt[c_sum_w-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_q   <= ref_in;
            r_fb_q    <= fb_in;
            r_state   <= c_st_idle;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_ref_q   <= ref_in;
            r_fb_q    <= fb_in;
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_x       <= w_x_nxt;
            r_x_valid <= w_last;
            r_timeout <= w_timeout;
            if (w_last) begin
                r_cnt <= '0;
                r_sum <= '0;
            end else if (w_vote) begin
                r_cnt <= r_cnt + 1'b1;
                r_sum <= w_sum_nxt;
            end
        end
    end

    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign timeout = r_timeout;

`ifdef BBPD_LOCK_DET_EN
    localparam int c_alt_w = $clog2(LOCK_CNT + 1);
    localparam logic [c_alt_w-1:0] c_alt_max = c_alt_w'(LOCK_CNT);

    logic [c_alt_w-1:0] r_alt_cnt;
    logic [c_alt_w-1:0] w_alt_nxt;
    logic               r_lock;

    always_comb begin
        w_alt_nxt = r_alt_cnt;
        if (w_timeout) begin
            w_alt_nxt = '0;
        end else if (w_last) begin
            if ((w_x_nxt != r_x) && (w_sum_nxt != '0)) begin
                w_alt_nxt = (r_alt_cnt == c_alt_max) ? c_alt_max : r_alt_cnt + 1'b1;
            end else begin
                w_alt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alt_cnt <= '0;
            r_lock    <= 1'b0;
        end else begin
            r_alt_cnt <= w_alt_nxt;
            r_lock    <= (w_alt_nxt == c_alt_max);
        end
    end

    assign lock = r_lock;
`else
    assign lock = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bb_phase_detector.sv
// ============================================================================
//  Module   : tb_bb_phase_detector
//  Brief    : Self-checking bench for bb_phase_detector (scenario table plus
//             scoreboard of expected strobes and timeouts).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bb_phase_detector;

    localparam int VOTE_LEN = 4;
    localparam int TIMEOUT  = 16;
    localparam int LOCK_CNT = 4;
    localparam int PERIOD   = 20;
    localparam int GAP      = 20;
`ifdef BBPD_LOCK_DET_EN
    localparam bit LOCK_EN  = 1'b1;
`else
    localparam bit LOCK_EN  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ref_in;
    logic fb_in;
    logic x;
    logic x_valid;
    logic timeout;
    logic lock;

    always #5 clk = ~clk;

    bb_phase_detector #(
        .VOTE_LEN (VOTE_LEN),
        .TIMEOUT  (TIMEOUT),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ref_in  (ref_in),
        .fb_in   (fb_in),
        .x       (x),
        .x_valid (x_valid),
        .timeout (timeout),
        .lock    (lock)
    );

    typedef struct {
        bit x;
        bit lock;
        int cyc;
    } exp_t;

    typedef struct {
        int n;
        int ref_off;
        int fb_off;
        int exp_strobes;
        int exp_tos;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   strobes_seen = 0;
    int   tos_seen     = 0;
    exp_t sb_q[$];
    int   to_q[$];

    int   win_cnt = 0;
    int   win_sum = 0;
    int   alt     = 0;
    bit   exp_x   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec-level expectation of the decision that closes a window
    task automatic note_vote(input int v, input int c);
        bit nx;
        win_sum += v;
        win_cnt++;
        if (win_cnt == VOTE_LEN) begin
            nx = (win_sum > 0) ? 1'b1 : (win_sum < 0) ? 1'b0 : exp_x;
            if ((nx != exp_x) && (win_sum != 0))
                alt = (alt < LOCK_CNT) ? alt + 1 : LOCK_CNT;
            else
                alt = 0;
            exp_x = nx;
            sb_q.push_back('{x: nx, lock: (LOCK_EN && (alt == LOCK_CNT)), cyc: c + 1});
            win_cnt = 0;
            win_sum = 0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   tc;
        if (x_valid) begin
            strobes_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_x_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("x", int'(x), int'(e.x));
                check("x_valid_cycle", cyc, e.cyc);
                check("lock", int'(lock), int'(e.lock));
            end
        end
        if (timeout) begin
            tos_seen++;
            if (to_q.size() == 0) begin
                check("unexpected_timeout", 1, 0);
            end else begin
                tc = to_q.pop_front();
                check("timeout_cycle", cyc, tc);
            end
        end
    end

    task automatic step(input logic r, input logic f);
        @(posedge clk);
        #1;
        ref_in = r;
        fb_in  = f;
    endtask

    // n periods; offsets place each signal's rising edge, -1 = never rises
    task automatic run_scn(input int n, input int ref_off, input int fb_off);
        int  later;
        bit  rr;
        bit  r;
        bit  f;
        later = (ref_off > fb_off) ? ref_off : fb_off;
        for (int g = 0; g < n * PERIOD; g++) begin
            r  = (ref_off >= 0) && (g >= ref_off) && (((g - ref_off) % PERIOD) < PERIOD / 2);
            f  = (fb_off  >= 0) && (g >= fb_off)  && (((g - fb_off)  % PERIOD) < PERIOD / 2);
            rr = (ref_off >= 0) && (g >= ref_off) && (((g - ref_off) % PERIOD) == 0);
            step(r, f);
            if ((ref_off >= 0) && (fb_off >= 0) && (ref_off != fb_off) &&
                (g >= later) && (((g - later) % PERIOD) == 0))
                note_vote((fb_off > ref_off) ? 1 : -1, cyc);
            if ((fb_off < 0) && rr) begin
                to_q.push_back(cyc + TIMEOUT + 1);
                alt = 0;
            end
        end
        repeat (GAP) step(1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic r, input logic f);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        ref_in = r;
        fb_in  = f;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        win_cnt = 0;
        win_sum = 0;
        alt     = 0;
        exp_x   = 1'b0;
        @(negedge clk);
        check("rst_x", int'(x), 0);
        check("rst_x_valid", int'(x_valid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_lock", int'(lock), 0);
    endtask

    task automatic run_checked(input string name, input int n, input int ro, input int fo,
                               input int exp_s, input int exp_t);
        int s0;
        int t0;
        s0 = strobes_seen;
        t0 = tos_seen;
        run_scn(n, ro, fo);
        check($sformatf("%s_strobes", name), strobes_seen - s0, exp_s);
        check($sformatf("%s_timeouts", name), tos_seen - t0, exp_t);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{n: 8,  ref_off: 0, fb_off: 3,  exp_strobes: 2, exp_tos: 0};
        vecs[1] = '{n: 2,  ref_off: 3, fb_off: 0,  exp_strobes: 0, exp_tos: 0};
        vecs[2] = '{n: 3,  ref_off: 0, fb_off: -1, exp_strobes: 0, exp_tos: 3};
        vecs[3] = '{n: 6,  ref_off: 3, fb_off: 0,  exp_strobes: 2, exp_tos: 0};
        vecs[4] = '{n: 10, ref_off: 0, fb_off: 0,  exp_strobes: 0, exp_tos: 0};
        vecs[5] = '{n: 4,  ref_off: 0, fb_off: 3,  exp_strobes: 1, exp_tos: 0};
        vecs[6] = '{n: 2,  ref_off: 0, fb_off: 3,  exp_strobes: 0, exp_tos: 0};
        vecs[7] = '{n: 2,  ref_off: 3, fb_off: 0,  exp_strobes: 1, exp_tos: 0};
        vecs[8] = '{n: 3,  ref_off: 0, fb_off: 3,  exp_strobes: 0, exp_tos: 0};

        rst    = 1'b1;
        ref_in = 1'b0;
        fb_in  = 1'b0;

        // ref held high across reset release must not start a comparison
        do_reset(1'b1, 1'b0);
        repeat (TIMEOUT + 10) step(1'b1, 1'b0);
        repeat (GAP) step(1'b0, 1'b0);

        for (int i = 0; i < 9; i++)
            run_checked($sformatf("vec%0d", i), vecs[i].n, vecs[i].ref_off, vecs[i].fb_off,
                        vecs[i].exp_strobes, vecs[i].exp_tos);
        check("x_after_tie", int'(x), 1);

        // Mid-window reset: three late votes are discarded
        do_reset(1'b0, 1'b0);
        repeat (GAP) step(1'b0, 1'b0);
        run_checked("post_rst", 4, 0, 3, 1, 0);

        // Alternating windows build lock, a repeated decision drops it
        run_checked("alt1", 4, 3, 0, 1, 0);
        run_checked("alt2", 4, 0, 3, 1, 0);
        run_checked("alt3", 4, 3, 0, 1, 0);
        check("lock_held", int'(lock), LOCK_EN ? 1 : 0);
        run_checked("same", 4, 3, 0, 1, 0);
        check("lock_dropped", int'(lock), 0);

        repeat (5) step(1'b0, 1'b0);
        check("sb_empty", sb_q.size(), 0);
        check("to_q_empty", to_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
